gravity_ctrl: RTL and testbench

//  Player-state controller that sits directly in front of move_player.
//  - Consumes the player height and the current line-presence bits.
//  - Produces the grav_dir and is_dead inputs that drive move_player.
//  - Turns a raw flip button into gravity flips. A flip is allowed only while the player stands on a line.
//  - Detects death when the player leaves the playfield.

---
 rtl/gravity_ctrl_pkg.sv | 32 +++
 rtl/gravity_ctrl_if.sv | 23 ++
 rtl/gravity_ctrl_btn_debounce.sv | 45 ++++
 rtl/gravity_ctrl.sv | 141 ++++++++++++++
 tb/tb_gravity_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gravity_ctrl_pkg.sv
// Shared constants, state encoding and the grounded rule for gravity_ctrl.
package gravity_ctrl_pkg;

  localparam int unsigned LINE_TOP = 120;
  localparam int unsigned LINE_MID = 240;
  localparam int unsigned LINE_BOT = 360;
  localparam int unsigned PLAYER_H = 60;

  // Falling players rest with their bottom edge on the line, so the top-left y
  // sits one player height above it. Rising players rest with their top edge on it.
  localparam logic [8:0] LAND_DN_MID = 9'(LINE_MID - PLAYER_H);
  localparam logic [8:0] LAND_DN_BOT = 9'(LINE_BOT - PLAYER_H);
  localparam logic [8:0] LAND_UP_TOP = 9'(LINE_TOP);
  localparam logic [8:0] LAND_UP_MID = 9'(LINE_MID);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    AIR  = 2'd1,
    DEAD = 2'd2
  } state_t;

  // True when the player is resting on a present line for the given gravity.
  function automatic logic is_grounded(input logic       dir,
                                       input logic [8:0] h,
                                       input logic [2:0] l);
    if (!dir)
      return ((h == LAND_DN_MID) && l[1]) || ((h == LAND_DN_BOT) && l[2]);
    else
      return ((h == LAND_UP_TOP) && l[0]) || ((h == LAND_UP_MID) && l[1]);
  endfunction

endpackage

// File: rtl/gravity_ctrl_if.sv
// Player-state bus between move_player side logic and gravity_ctrl.
interface gravity_ctrl_if;

  logic       btn_flip;
  logic [8:0] height;
  logic [2:0] lines;
  logic       grav_dir;
  logic       is_dead;
  logic       grounded;
  logic       flip_pulse;
  logic [7:0] flip_count;

  modport master (
    output btn_flip, height, lines,
    input  grav_dir, is_dead, grounded, flip_pulse, flip_count
  );

  modport slave (
    input  btn_flip, height, lines,
    output grav_dir, is_dead, grounded, flip_pulse, flip_count
  );

endinterface

// File: rtl/gravity_ctrl_btn_debounce.sv
// Flip button conditioning: 2-FF synchroniser, debounce counter and
// rising-edge detect producing a one-cycle flip_req.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_flip,
  output logic flip_req
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync_q1;
  logic          sync_q2;
  logic          level_q;
  logic          level_d_q;
  logic [CW-1:0] cnt_q;

  // Synchronise, then accept a new level after DEBOUNCE_CYCLES equal samples.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      level_q   <= 1'b0;
      level_d_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync_q1   <= btn_flip;
      sync_q2   <= sync_q1;
      level_d_q <= level_q;
      if (sync_q2 == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= sync_q2;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign flip_req = level_q & ~level_d_q;

endmodule

// File: rtl/gravity_ctrl.sv
// Player-state controller in front of move_player: gravity flips, landing
// detection and death detection.
// Optional feature: define GRAV_FLIP_BUFFER_EN to buffer flip requests made
// in the air and execute them on landing.
module gravity_ctrl
  import gravity_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HEIGHT_MAX      = 420,
  parameter int unsigned BUFFER_CYCLES   = 8
) (
  input  logic           clk,
  input  logic           reset,
  gravity_ctrl_if.slave  bus
);

  state_t     state_q, state_n;
  logic       grav_q, grav_n;
  logic       pulse_q, pulse_n;
  logic       dead_q;
  logic [7:0] count_q, count_n;
  logic       do_flip;
  logic       flip_req;
  logic       grounded;
  logic       too_high;
  logic       buf_hit;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .btn_flip (bus.btn_flip),
    .flip_req (flip_req)
  );

  assign grounded = is_grounded(grav_q, bus.height, bus.lines);
  // 9-bit underflow wraps to 511, which this compare also catches.
  assign too_high = 32'(bus.height) > HEIGHT_MAX;

`ifdef GRAV_FLIP_BUFFER_EN
  localparam int unsigned BW = $clog2(BUFFER_CYCLES + 1);

  logic [BW-1:0] buf_q, buf_n;

  assign buf_hit = (buf_q != '0);

  // Buffer lives only in AIR: load on request, count down, drop on landing/death.
  always_comb begin
    buf_n = '0;
    if ((state_q == AIR) && !too_high) begin
      if (grounded && buf_hit)
        buf_n = '0;
      else if (flip_req)
        buf_n = BW'(BUFFER_CYCLES);
      else if (buf_hit)
        buf_n = buf_q - BW'(1);
    end
  end

  // Buffer countdown register.
  always_ff @(posedge clk) begin
    if (!reset)
      buf_q <= '0;
    else
      buf_q <= buf_n;
  end
`else
  assign buf_hit = 1'b0;
`endif

  // Next-state and output decode; death outranks any flip.
  always_comb begin
    state_n = state_q;
    grav_n  = grav_q;
    pulse_n = 1'b0;
    count_n = count_q;
    do_flip = 1'b0;
    case (state_q)
      RUN: begin
        if (too_high) begin
          state_n = DEAD;
        end else if (flip_req && grounded) begin
          do_flip = 1'b1;
          state_n = AIR;
        end else if (!grounded) begin
          state_n = AIR;
        end
      end
      AIR: begin
        if (too_high) begin
          state_n = DEAD;
        end else if (grounded) begin
          // A buffered flip fires on the landing cycle, so the player leaves again.
          if (buf_hit) begin
            do_flip = 1'b1;
            state_n = AIR;
          end else begin
            state_n = RUN;
          end
        end
      end
      DEAD: begin
        state_n = DEAD;
      end
      default: begin
        state_n = RUN;
      end
    endcase
    if (do_flip) begin
      grav_n  = ~grav_q;
      pulse_n = 1'b1;
      if (count_q != 8'hFF)
        count_n = count_q + 8'd1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      grav_q  <= 1'b0;
      pulse_q <= 1'b0;
      dead_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_n;
      grav_q  <= grav_n;
      pulse_q <= pulse_n;
      dead_q  <= (state_n == DEAD);
      count_q <= count_n;
    end
  end

  assign bus.grav_dir   = grav_q;
  assign bus.is_dead    = dead_q;
  assign bus.grounded   = grounded;
  assign bus.flip_pulse = pulse_q;
  assign bus.flip_count = count_q;

endmodule

// File: tb/tb_gravity_ctrl.sv
// Self-checking bench for gravity_ctrl: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_gravity_ctrl;

  localparam int DB   = 4;
  localparam int HMAX = 420;
  localparam int BUFC = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  gravity_ctrl_if bus();

  gravity_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .HEIGHT_MAX      (HMAX),
    .BUFFER_CYCLES   (BUFC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  int       m_hist[$];
  bit       m_lvl, m_lvl_d;
  bit       m_gd, m_dead, m_air, m_pulse;
  int       m_cnt, m_buf;
  int       cur_h;
  bit [2:0] cur_l;

  typedef struct {
    bit       rn;
    int       h;
    bit [2:0] l;
    bit       e_gr;
    bit       e_dead;
    bit       e_gd;
  } vec_t;

  vec_t tbl[14];

  function automatic bit m_ground(input bit gd, input int h, input bit [2:0] l);
    if (!gd) return ((h == 180) && l[1]) || ((h == 300) && l[2]);
    else     return ((h == 120) && l[0]) || ((h == 240) && l[1]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic model_edge(input bit rn, input bit b, input int h, input bit [2:0] l);
    bit freq, gr, flip, same;
    if (!rn) begin
      m_hist.delete();
      repeat (DB + 2) m_hist.push_back(0);
      m_lvl = 0; m_lvl_d = 0; m_gd = 0; m_dead = 0; m_air = 0;
      m_pulse = 0; m_cnt = 0; m_buf = 0;
      return;
    end
    freq = m_lvl && !m_lvl_d;
    m_hist.push_back(int'(b));
    if (m_hist.size() > DB + 2) void'(m_hist.pop_front());
    // Oldest DB entries are the button values that have cleared the synchroniser.
    same = 1;
    for (int i = 1; i < DB; i++) if (m_hist[i] != m_hist[0]) same = 0;
    m_lvl_d = m_lvl;
    if (same && (m_hist[0] != int'(m_lvl))) m_lvl = (m_hist[0] != 0);

    gr = m_ground(m_gd, h, l);
    m_pulse = 0;
    flip = 0;
    if (m_dead) begin
      m_buf = 0;
    end else if (h > HMAX) begin
      m_dead = 1;
      m_buf = 0;
    end else if (!m_air) begin
      m_buf = 0;
      if (freq && gr) flip = 1;
      else if (!gr) m_air = 1;
    end else begin
`ifdef GRAV_FLIP_BUFFER_EN
      if (gr && m_buf > 0) begin
        flip = 1;
        m_buf = 0;
      end else begin
        if (gr) m_air = 0;
        if (freq) m_buf = BUFC;
        else if (m_buf > 0) m_buf--;
      end
`else
      if (gr) m_air = 0;
`endif
    end
    if (flip) begin
      m_gd = !m_gd;
      m_pulse = 1;
      m_air = 1;
      if (m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic check_model();
    chk("grav_dir",   int'(bus.grav_dir),   int'(m_gd));
    chk("is_dead",    int'(bus.is_dead),    int'(m_dead));
    chk("flip_pulse", int'(bus.flip_pulse), int'(m_pulse));
    chk("flip_count", int'(bus.flip_count), m_cnt);
    chk("grounded",   int'(bus.grounded),   int'(m_ground(m_gd, cur_h, cur_l)));
  endtask

  // Drive one cycle of inputs, step the model, and compare at the next negedge.
  task automatic step(input bit rn, input bit b, input int h, input bit [2:0] l);
    logic [8:0] hv;
    hv = 9'(h);
    reset = rn;
    bus.btn_flip = b;
    bus.height = hv;
    bus.lines = l;
    cur_h = int'(hv);
    cur_l = l;
    model_edge(rn, b, int'(hv), l);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int run_len;
    bit btn;
    int r, h;

    reset = 1'b0;
    bus.btn_flip = 1'b0;
    bus.height = 9'd180;
    bus.lines = 3'b010;
    cur_h = 180;
    cur_l = 3'b010;

    // Reset, grounded rule and death boundaries (button idle).
    tbl[0]  = '{0, 180, 3'b010, 1, 0, 0};
    tbl[1]  = '{0, 180, 3'b010, 1, 0, 0};
    tbl[2]  = '{1, 180, 3'b010, 1, 0, 0};
    tbl[3]  = '{1, 180, 3'b000, 0, 0, 0};
    tbl[4]  = '{1, 300, 3'b100, 1, 0, 0};
    tbl[5]  = '{1, 300, 3'b011, 0, 0, 0};
    tbl[6]  = '{1, 120, 3'b001, 0, 0, 0};
    tbl[7]  = '{1, 420, 3'b000, 0, 0, 0};
    tbl[8]  = '{1, 421, 3'b000, 0, 1, 0};
    tbl[9]  = '{1, 180, 3'b010, 1, 1, 0};
    tbl[10] = '{0, 180, 3'b010, 1, 0, 0};
    tbl[11] = '{1, 511, 3'b000, 0, 1, 0};
    tbl[12] = '{0,   0, 3'b000, 0, 0, 0};
    tbl[13] = '{1,   0, 3'b000, 0, 0, 0};
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rn, 1'b0, tbl[i].h, tbl[i].l);
      chk($sformatf("tbl%0d_grounded", i), int'(bus.grounded), int'(tbl[i].e_gr));
      chk($sformatf("tbl%0d_is_dead", i),  int'(bus.is_dead),  int'(tbl[i].e_dead));
      chk($sformatf("tbl%0d_grav_dir", i), int'(bus.grav_dir), int'(tbl[i].e_gd));
      chk($sformatf("tbl%0d_count", i),    int'(bus.flip_count), 0);
    end

    // Clean press while grounded: single pulse on the 7th edge after the press is driven.
    step(0, 0, 180, 3'b010);
    step(1, 0, 180, 3'b010);
    pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      step(1, 1, 180, 3'b010);
      chk($sformatf("press_pulse_c%0d", c), int'(bus.flip_pulse), (c == 7) ? 1 : 0);
      pulses += int'(bus.flip_pulse);
    end
    chk("press_pulses", pulses, 1);
    chk("press_grav_dir", int'(bus.grav_dir), 1);
    chk("press_count", int'(bus.flip_count), 1);
    for (int c = 0; c < 10; c++) step(1, 0, 120, 3'b001);
    chk("land_up_grounded", int'(bus.grounded), 1);

    // Bounce 1-0-1-0 never settles long enough to be accepted.
    pulses = 0;
    step(1, 1, 120, 3'b001); pulses += int'(bus.flip_pulse);
    step(1, 0, 120, 3'b001); pulses += int'(bus.flip_pulse);
    step(1, 1, 120, 3'b001); pulses += int'(bus.flip_pulse);
    step(1, 0, 120, 3'b001); pulses += int'(bus.flip_pulse);
    for (int c = 0; c < 10; c++) begin
      step(1, 0, 120, 3'b001);
      pulses += int'(bus.flip_pulse);
    end
    chk("bounce_pulses", pulses, 0);
    chk("bounce_grav_dir", int'(bus.grav_dir), 1);
    chk("bounce_count", int'(bus.flip_count), 1);

    // Press in the air, then land at 300 on the bottom line.
    step(0, 0, 200, 3'b000);
    step(1, 0, 200, 3'b000);
    pulses = 0;
    for (int c = 1; c <= 7; c++) begin
      step(1, 1, 200, 3'b000);
      pulses += int'(bus.flip_pulse);
    end
    for (int c = 8; c <= 12; c++) begin
      step(1, 1, 300, 3'b100);
      pulses += int'(bus.flip_pulse);
    end
`ifdef GRAV_FLIP_BUFFER_EN
    chk("air_press_pulses", pulses, 1);
    chk("air_press_grav_dir", int'(bus.grav_dir), 1);
`else
    chk("air_press_pulses", pulses, 0);
    chk("air_press_grav_dir", int'(bus.grav_dir), 0);
`endif

    // Death at HEIGHT_MAX+1 is sticky and ignores the button.
    step(0, 0, 180, 3'b010);
    step(1, 0, 420, 3'b000);
    chk("h420_alive", int'(bus.is_dead), 0);
    step(1, 0, 421, 3'b000);
    chk("h421_dead", int'(bus.is_dead), 1);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      step(1, (c < 8), 180, 3'b010);
      pulses += int'(bus.flip_pulse);
    end
    chk("dead_pulses", pulses, 0);
    chk("dead_sticky", int'(bus.is_dead), 1);
    chk("dead_grav_dir", int'(bus.grav_dir), 0);
    step(0, 0, 180, 3'b010);
    chk("dead_reset_is_dead", int'(bus.is_dead), 0);
    chk("dead_reset_grav_dir", int'(bus.grav_dir), 0);
    step(1, 0, 180, 3'b010);
    chk("after_reset_alive", int'(bus.is_dead), 0);

    // 256 grounded flips: count saturates, direction toggles every time.
    step(0, 0, 180, 3'b010);
    pulses = 0;
    for (int f = 0; f < 256; f++) begin
      for (int c = 0; c < 12; c++) begin
        step(1, (c < 6), m_gd ? 240 : 180, 3'b010);
        pulses += int'(bus.flip_pulse);
      end
    end
    chk("sat_pulses", pulses, 256);
    chk("sat_count", int'(bus.flip_count), 255);
    chk("sat_grav_dir", int'(bus.grav_dir), 0);

    // Randomized traffic against the model.
    step(0, 0, 180, 3'b010);
    btn = 0;
    run_len = 3;
    for (int c = 0; c < 3000; c++) begin
      if (run_len == 0) begin
        btn = !btn;
        run_len = $urandom_range(1, 9);
      end
      run_len--;
      r = $urandom_range(0, 99);
      if (r < 2)       h = ($urandom_range(0, 1) != 0) ? 511 : 421;
      else if (r < 20) h = m_gd ? 120 : 180;
      else if (r < 40) h = m_gd ? 240 : 300;
      else if (r < 50) h = 420;
      else if (r < 60) h = 200;
      else             h = $urandom_range(0, 420);
      step(($urandom_range(0, 79) != 0), btn, h, 3'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
